rob_flush_ctrl: RTL

ROB-side receiver for branch-misprediction broadcasts from the branch checker. It captures the mispredicted branch's ROB tag and walks the ROB from youngest entry back to the branch, squashing one entry per cycle. It then restores the ROB tail and issues a fetch/rename redirect. It stalls issue for the duration and arbitrates overlapping mispredictions by age.

---
 rtl/rob_flush_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/rob_flush_ctrl.sv
// rob_flush_ctrl: ROB-side branch-misprediction flush controller.
// Captures a mispredicted branch tag, squashes younger ROB entries one per
// cycle (youngest first), then restores the ROB tail and redirects fetch.
// A newer broadcast for an older, still-unsquashed branch retargets an
// ongoing walk without squashing any entry twice.
// Optional build macro FLUSH_STATS_EN: enables the saturating completed-flush
// counter on flush_count; without it flush_count is tied to zero.
module rob_flush_ctrl #(
    parameter int ROB_DEPTH = 8,
    parameter int TAG_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             branch_valid_output,
    input  logic [TAG_W-1:0] branch_broadcasted_tag,
    input  logic [TAG_W-1:0] rob_head,
    input  logic [TAG_W-1:0] rob_tail,
    input  logic [TAG_W:0]   rob_count,
    output logic             squash_valid,
    output logic [TAG_W-1:0] squash_tag,
    output logic             tail_restore_valid,
    output logic [TAG_W-1:0] tail_restore,
    output logic             redirect_valid,
    output logic [TAG_W-1:0] redirect_tag,
    output logic             stall_issue,
    output logic [15:0]      flush_count
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WALK    = 2'd1,
        ST_RESTORE = 2'd2
    } state_e;

    localparam logic [TAG_W-1:0] TAG_ONE = TAG_W'(1);
    localparam logic [TAG_W:0]   DEPTH_L = (TAG_W+1)'(ROB_DEPTH);

    // Distance of a tag from the ROB head; arithmetic wraps at ROB_DEPTH.
    function automatic logic [TAG_W-1:0] tag_age(input logic [TAG_W-1:0] tag,
                                                 input logic [TAG_W-1:0] head);
        return tag - head;
    endfunction

    state_e           state_q, state_d;
    logic [TAG_W-1:0] target_q, target_d;
    logic [TAG_W-1:0] walk_ptr_q, walk_ptr_d;
    logic [TAG_W-1:0] head_q, head_d;

    logic             squash_valid_q, squash_valid_d;
    logic [TAG_W-1:0] squash_tag_q, squash_tag_d;
    logic             tail_restore_valid_q, tail_restore_valid_d;
    logic [TAG_W-1:0] tail_restore_q, tail_restore_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [TAG_W-1:0] redirect_tag_q, redirect_tag_d;
    logic             stall_issue_q, stall_issue_d;

    logic             in_flight_s;
    logic             older_than_target_s;
    logic [TAG_W-1:0] tail_minus_one_s;

    // A count above ROB_DEPTH is malformed; such a broadcast is ignored.
    assign in_flight_s = ({1'b0, tag_age(branch_broadcasted_tag, rob_head)} < rob_count)
                         && (rob_count <= DEPTH_L);
    // Older than the current target means every such entry is still unsquashed.
    assign older_than_target_s = tag_age(branch_broadcasted_tag, head_q)
                                 < tag_age(target_q, head_q);
    assign tail_minus_one_s    = rob_tail - TAG_ONE;

    // State and walk bookkeeping registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            target_q   <= '0;
            walk_ptr_q <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            walk_ptr_q <= walk_ptr_d;
            head_q     <= head_d;
        end
    end

    // Next-state logic: accept, walk, retarget on older broadcast, restore.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        walk_ptr_d = walk_ptr_q;
        head_d     = head_q;
        case (state_q)
            ST_IDLE: begin
                if (branch_valid_output && in_flight_s) begin
                    target_d   = branch_broadcasted_tag;
                    walk_ptr_d = tail_minus_one_s;
                    head_d     = rob_head;
                    if (branch_broadcasted_tag == tail_minus_one_s) begin
                        state_d = ST_RESTORE;
                    end else begin
                        state_d = ST_WALK;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WALK: begin
                walk_ptr_d = walk_ptr_q - TAG_ONE;
                if (branch_valid_output && older_than_target_s) begin
                    // The new target is strictly older, so the walk cannot end here.
                    target_d = branch_broadcasted_tag;
                    state_d  = ST_WALK;
                end else if (walk_ptr_q == (target_q + TAG_ONE)) begin
                    state_d = ST_RESTORE;
                end else begin
                    state_d = ST_WALK;
                end
            end
            ST_RESTORE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the strobes leave a register.
    always_comb begin
        squash_valid_d       = 1'b0;
        squash_tag_d         = '0;
        tail_restore_valid_d = 1'b0;
        tail_restore_d       = '0;
        redirect_valid_d     = 1'b0;
        redirect_tag_d       = '0;
        stall_issue_d        = 1'b0;
        case (state_d)
            ST_IDLE: begin
                stall_issue_d = 1'b0;
            end
            ST_WALK: begin
                squash_valid_d = 1'b1;
                squash_tag_d   = walk_ptr_d;
                stall_issue_d  = 1'b1;
            end
            ST_RESTORE: begin
                tail_restore_valid_d = 1'b1;
                tail_restore_d       = target_d + TAG_ONE;
                redirect_valid_d     = 1'b1;
                redirect_tag_d       = target_d;
                stall_issue_d        = 1'b1;
            end
            default: begin
                stall_issue_d = 1'b0;
            end
        endcase
    end

    // Output registers; reset drops every strobe immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            squash_valid_q       <= 1'b0;
            squash_tag_q         <= '0;
            tail_restore_valid_q <= 1'b0;
            tail_restore_q       <= '0;
            redirect_valid_q     <= 1'b0;
            redirect_tag_q       <= '0;
            stall_issue_q        <= 1'b0;
        end else begin
            squash_valid_q       <= squash_valid_d;
            squash_tag_q         <= squash_tag_d;
            tail_restore_valid_q <= tail_restore_valid_d;
            tail_restore_q       <= tail_restore_d;
            redirect_valid_q     <= redirect_valid_d;
            redirect_tag_q       <= redirect_tag_d;
            stall_issue_q        <= stall_issue_d;
        end
    end

    assign squash_valid       = squash_valid_q;
    assign squash_tag         = squash_tag_q;
    assign tail_restore_valid = tail_restore_valid_q;
    assign tail_restore       = tail_restore_q;
    assign redirect_valid     = redirect_valid_q;
    assign redirect_tag       = redirect_tag_q;
    assign stall_issue        = stall_issue_q;

`ifdef FLUSH_STATS_EN
    logic [15:0] flush_count_q;

    // Completed-flush counter: one per RESTORE cycle, saturating.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flush_count_q <= 16'h0000;
        end else if ((state_q == ST_RESTORE) && (flush_count_q != 16'hFFFF)) begin
            flush_count_q <= flush_count_q + 16'h0001;
        end else begin
            flush_count_q <= flush_count_q;
        end
    end

    assign flush_count = flush_count_q;
`else
    assign flush_count = 16'h0000;
`endif

endmodule
